// File: rtl/clk_pkg.sv
// rtl/clk_pkg.sv - shared FSM states, field codes and wrap limits for time_set_ctrl
package clk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EDIT_HR,
    ST_EDIT_MIN,
    ST_EDIT_SEC,
    ST_COMMIT
  } state_e;

  typedef enum logic [1:0] {
    FIELD_NONE = 2'd0,
    FIELD_HOUR = 2'd1,
    FIELD_MIN  = 2'd2,
    FIELD_SEC  = 2'd3
  } field_e;

  localparam logic [5:0] HOUR_MAX   = 6'd23;
  localparam logic [5:0] MINSEC_MAX = 6'd59;

  // One step up or down with wrap at the field's maximum.
  function automatic logic [5:0] wrap_step(input logic [5:0] val, input logic [5:0] max,
                                           input logic up);
    if (up) return (val >= max) ? 6'd0 : val + 6'd1;
    else    return (val == 6'd0) ? max : val - 6'd1;
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// rtl/btn_repeat.sv - button edge detect with hold-then-repeat, one-cycle step pulse
module btn_repeat #(
  parameter int HOLD_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic step_o
);

  localparam int CMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  logic          r_prev;
  logic          r_rep;
  logic          r_step;
  logic [CW-1:0] r_cnt;

  // r_cnt holds the number of high samples since the press or the last repeat.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_prev <= 1'b0;
      r_rep  <= 1'b0;
      r_step <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_prev <= btn_i;
      if (!btn_i) begin
        r_cnt  <= '0;
        r_rep  <= 1'b0;
        r_step <= 1'b0;
      end else if (!r_prev) begin
        r_cnt  <= CW'(1);
        r_rep  <= 1'b0;
        r_step <= 1'b1;
      end else if (r_cnt == (r_rep ? CW'(REPEAT_CYCLES) : CW'(HOLD_CYCLES))) begin
        r_cnt  <= CW'(1);
        r_rep  <= 1'b1;
        r_step <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + CW'(1);
        r_step <= 1'b0;
      end
    end
  end

  assign step_o = r_step;

endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - front-panel hour/min/sec editor driving the clock set port
// Optional decrement button and behaviour enabled by TIME_SET_DEC_EN.
module time_set_ctrl
  import clk_pkg::*;
#(
  parameter int HOLD_CYCLES    = 8,
  parameter int REPEAT_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TS_CYCLES      = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       mode_i,
  input  logic       inc_i,
`ifdef TIME_SET_DEC_EN
  input  logic       dec_i,
`endif
  input  logic [4:0] cur_hour_i,
  input  logic [5:0] cur_min_i,
  input  logic [5:0] cur_sec_i,
  output logic       Timeset,
  output logic [4:0] Hourset,
  output logic [5:0] Minset,
  output logic [5:0] Secset,
  output logic [1:0] edit_field_o,
  output logic       busy_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(TS_CYCLES + 1);

  state_e        r_state;
  field_e        r_field;
  logic          r_busy;
  logic          r_ts;
  logic          r_mode_prev;
  logic          r_mode_press;
  logic [4:0]    r_hour;
  logic [5:0]    r_min;
  logic [5:0]    r_sec;
  logic [TW-1:0] r_idle_cnt;
  logic [SW-1:0] r_ts_cnt;

  logic w_inc_step;
  logic w_adj;
  logic w_up;
  logic w_act;

  btn_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_inc (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .btn_i  (inc_i),
    .step_o (w_inc_step)
  );

`ifdef TIME_SET_DEC_EN
  logic w_dec_step;

  btn_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_dec (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .btn_i  (dec_i),
    .step_o (w_dec_step)
  );

  // Opposing steps in the same cycle cancel but still count as activity.
  assign w_adj = w_inc_step ^ w_dec_step;
  assign w_up  = w_inc_step;
  assign w_act = w_inc_step | w_dec_step;
`else
  assign w_adj = w_inc_step;
  assign w_up  = 1'b1;
  assign w_act = w_inc_step;
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_state      <= ST_IDLE;
      r_field      <= FIELD_NONE;
      r_busy       <= 1'b0;
      r_ts         <= 1'b0;
      r_mode_prev  <= 1'b0;
      r_mode_press <= 1'b0;
      r_hour       <= '0;
      r_min        <= '0;
      r_sec        <= '0;
      r_idle_cnt   <= '0;
      r_ts_cnt     <= '0;
    end else begin
      r_mode_prev  <= mode_i;
      r_mode_press <= mode_i & ~r_mode_prev;
      case (r_state)
        ST_IDLE: begin
          if (r_mode_press) begin
            r_hour     <= cur_hour_i;
            r_min      <= cur_min_i;
            r_sec      <= cur_sec_i;
            r_state    <= ST_EDIT_HR;
            r_field    <= FIELD_HOUR;
            r_busy     <= 1'b1;
            r_idle_cnt <= '0;
          end
        end
        ST_EDIT_HR, ST_EDIT_MIN, ST_EDIT_SEC: begin
          if (r_mode_press) begin
            r_idle_cnt <= '0;
            case (r_state)
              ST_EDIT_HR: begin
                r_state <= ST_EDIT_MIN;
                r_field <= FIELD_MIN;
              end
              ST_EDIT_MIN: begin
                r_state <= ST_EDIT_SEC;
                r_field <= FIELD_SEC;
              end
              default: begin
                r_state  <= ST_COMMIT;
                r_field  <= FIELD_NONE;
                r_ts     <= 1'b1;
                r_ts_cnt <= '0;
              end
            endcase
          end else if (w_act) begin
            r_idle_cnt <= '0;
            if (w_adj) begin
              case (r_state)
                ST_EDIT_HR:  r_hour <= 5'(wrap_step({1'b0, r_hour}, HOUR_MAX, w_up));
                ST_EDIT_MIN: r_min  <= wrap_step(r_min, MINSEC_MAX, w_up);
                default:     r_sec  <= wrap_step(r_sec, MINSEC_MAX, w_up);
              endcase
            end
          end else if (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            r_state <= ST_IDLE;
            r_field <= FIELD_NONE;
            r_busy  <= 1'b0;
          end else begin
            r_idle_cnt <= r_idle_cnt + TW'(1);
          end
        end
        ST_COMMIT: begin
          if (r_ts_cnt == SW'(TS_CYCLES - 1)) begin
            r_state <= ST_IDLE;
            r_ts    <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_ts_cnt <= r_ts_cnt + SW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_field <= FIELD_NONE;
          r_busy  <= 1'b0;
          r_ts    <= 1'b0;
        end
      endcase
    end
  end

  assign Timeset      = r_ts;
  assign Hourset      = r_hour;
  assign Minset       = r_min;
  assign Secset       = r_sec;
  assign edit_field_o = r_field;
  assign busy_o       = r_busy;

endmodule
